// File: rtl/bist_controller.sv
// Memory BIST sequencer: runs enabled pattern generators one at a time against a single SRAM
// port, compares read data one cycle after each read and records error count and first failure.
module bist_controller #(
    parameter int  MAX_ADDR     = 31,
    parameter int  DATA_WIDTH   = 8,
    parameter int  MASK_WIDTH   = 2,
    parameter int  NUM_PATTERNS = 3,
    localparam int ADDR_WIDTH   = $clog2(MAX_ADDR + 1),
    localparam int PSEL_WIDTH   = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [NUM_PATTERNS-1:0]            pattern_en_i,
    output logic [NUM_PATTERNS-1:0]            pg_rst_o,
    output logic [NUM_PATTERNS-1:0]            pg_en_o,
    input  logic [NUM_PATTERNS*ADDR_WIDTH-1:0] pg_addr_i,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_data_i,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_check_i,
    input  logic [NUM_PATTERNS*MASK_WIDTH-1:0] pg_mask_i,
    input  logic [NUM_PATTERNS-1:0]            pg_we_i,
    input  logic [NUM_PATTERNS-1:0]            pg_re_i,
    input  logic [NUM_PATTERNS-1:0]            pg_done_i,
    output logic [ADDR_WIDTH-1:0]              sram_addr_o,
    output logic [DATA_WIDTH-1:0]              sram_din_o,
    output logic [MASK_WIDTH-1:0]              sram_wmask_o,
    output logic                               sram_we_o,
    output logic                               sram_re_o,
    input  logic [DATA_WIDTH-1:0]              sram_dout_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               fail_o,
    output logic [15:0]                        err_count_o,
    output logic [ADDR_WIDTH-1:0]              fail_addr_o,
    output logic [PSEL_WIDTH-1:0]              fail_pattern_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PG_RST = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]              state_q,     state_d;
    logic [PSEL_WIDTH-1:0]   sel_q,       sel_d;
    logic [NUM_PATTERNS-1:0] en_q,        en_d;
    logic                    rst_cnt_q,   rst_cnt_d;
    logic [15:0]             err_q,       err_d;
    logic                    fail_q,      fail_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [PSEL_WIDTH-1:0]   fail_pat_q,  fail_pat_d;
    logic                    cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0]   cmp_check_q, cmp_check_d;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q,  cmp_addr_d;
    logic [PSEL_WIDTH-1:0]   cmp_sel_q,   cmp_sel_d;

    logic [ADDR_WIDTH-1:0]   sram_addr_s;
    logic [DATA_WIDTH-1:0]   sram_din_s;
    logic [MASK_WIDTH-1:0]   sram_wmask_s;
    logic                    sram_we_s;
    logic                    sram_re_s;
    logic                    mismatch_s;
    logic [PSEL_WIDTH:0]     first_s;
    logic [PSEL_WIDTH:0]     next_s;

    // Returns {found, index} of the lowest enabled generator at or above 'from'.
    function automatic logic [PSEL_WIDTH:0] find_enabled(
        input logic [NUM_PATTERNS-1:0] en,
        input int                      from
    );
        logic [PSEL_WIDTH:0] res;
        res = '0;
        for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
            if (en[i] && (i >= from)) begin
                res = {1'b1, PSEL_WIDTH'(i)};
            end
        end
        return res;
    endfunction

    assign first_s    = find_enabled(pattern_en_i, 0);
    assign next_s     = find_enabled(en_q, int'(sel_q) + 1);
    assign mismatch_s = cmp_valid_q && (sram_dout_i != cmp_check_q);

    // Generator handshake: only the selected generator in RUN is released from reset.
    always_comb begin
        pg_rst_o = '1;
        pg_en_o  = '0;
        if (state_q == ST_RUN) begin
            pg_rst_o[sel_q] = 1'b0;
            pg_en_o[sel_q]  = 1'b1;
        end else begin
            pg_rst_o = '1;
            pg_en_o  = '0;
        end
    end

    // SRAM port mux; a simultaneous write and read from a generator is treated as a write.
    always_comb begin
        sram_addr_s  = '0;
        sram_din_s   = '0;
        sram_wmask_s = '0;
        sram_we_s    = 1'b0;
        sram_re_s    = 1'b0;
        if (state_q == ST_RUN) begin
            sram_addr_s  = pg_addr_i[sel_q*ADDR_WIDTH +: ADDR_WIDTH];
            sram_din_s   = pg_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
            sram_wmask_s = pg_mask_i[sel_q*MASK_WIDTH +: MASK_WIDTH];
            sram_we_s    = pg_we_i[sel_q];
            sram_re_s    = pg_re_i[sel_q] & ~pg_we_i[sel_q];
        end else begin
            sram_we_s    = 1'b0;
            sram_re_s    = 1'b0;
        end
    end

    // Compare pipeline capture: expected data travels alongside the read.
    always_comb begin
        cmp_valid_d = sram_re_s;
        cmp_check_d = cmp_check_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_sel_d   = cmp_sel_q;
        if (sram_re_s) begin
            cmp_check_d = pg_check_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
            cmp_addr_d  = sram_addr_s;
            cmp_sel_d   = sel_q;
        end else begin
            cmp_check_d = cmp_check_q;
        end
    end

    // Sequencer next state and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_d        = en_q;
        rst_cnt_d   = rst_cnt_q;
        err_d       = err_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_pat_d  = fail_pat_q;

        if (mismatch_s) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end else begin
                err_d = err_q;
            end
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = cmp_addr_q;
                fail_pat_d  = cmp_sel_q;
            end else begin
                fail_d      = fail_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    en_d        = pattern_en_i;
                    err_d       = 16'd0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_pat_d  = '0;
                    rst_cnt_d   = 1'b0;
                    if (first_s[PSEL_WIDTH]) begin
                        sel_d   = first_s[PSEL_WIDTH-1:0];
                        state_d = ST_PG_RST;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PG_RST: begin
                if (rst_cnt_q) begin
                    rst_cnt_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (pg_done_i[sel_q]) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (next_s[PSEL_WIDTH]) begin
                    sel_d     = next_s[PSEL_WIDTH-1:0];
                    rst_cnt_d = 1'b0;
                    state_d   = ST_PG_RST;
                end else begin
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any in-flight compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            en_q        <= '0;
            rst_cnt_q   <= 1'b0;
            err_q       <= 16'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_pat_q  <= '0;
            cmp_valid_q <= 1'b0;
            cmp_check_q <= '0;
            cmp_addr_q  <= '0;
            cmp_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            rst_cnt_q   <= rst_cnt_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_pat_q  <= fail_pat_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_check_q <= cmp_check_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_sel_q   <= cmp_sel_d;
        end
    end

    assign sram_addr_o    = sram_addr_s;
    assign sram_din_o     = sram_din_s;
    assign sram_wmask_o   = sram_wmask_s;
    assign sram_we_o      = sram_we_s;
    assign sram_re_o      = sram_re_s;
    assign busy_o         = (state_q == ST_PG_RST) || (state_q == ST_RUN) ||
                            (state_q == ST_DRAIN)  || (state_q == ST_NEXT);
    assign done_o         = (state_q == ST_DONE);
    assign fail_o         = fail_q;
    assign err_count_o    = err_q;
    assign fail_addr_o    = fail_addr_q;
    assign fail_pattern_o = fail_pat_q;

endmodule
